// File: rtl/alu_writeback_stage_pkg.sv
// Shared definitions for the execute/writeback stage: default widths,
// ALU opcode encodings, FSM state encodings and a small opcode helper.
package alu_writeback_stage_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  // ALU opcodes
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  // MUL is the only opcode that takes more than one EXEC cycle.
  function automatic logic is_mul(input logic [2:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_writeback_stage_mul.sv
// Sequential shift-add multiplier: one partial-product step per cycle,
// returns the low DW bits of a*b. o_done/o_product are valid in the cycle
// that performs the final step, so the caller can leave on that same edge.
module alu_writeback_stage_mul #(
  parameter int DW    = 16,
  parameter int STEPS = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic          o_busy,
  output logic          o_done,
  output logic [DW-1:0] o_product
);

  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [DW-1:0] r_mcand;
  logic [DW-1:0] r_mplier;
  logic [DW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  logic [DW-1:0] w_acc_next;
  logic          w_last;

  // Add the shifted multiplicand whenever the current multiplier bit is set.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last     = r_busy && (r_cnt == CW'(STEPS - 1));

  assign o_busy    = r_busy;
  assign o_done    = w_last;
  assign o_product = w_acc_next;

  // Load operands on start, then perform one shift-add step per cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, regardless of order.
    if (!reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute/writeback stage around a 16x16 register file: accepts one decoded
// instruction, reads both sources, computes the ALU result (MUL takes
// MUL_CYC cycles) and issues a single-cycle write back into the register file.
module alu_writeback_stage
  import alu_writeback_stage_pkg::*;
#(
  parameter int DW      = DATA_W,
  parameter int AW      = ADDR_W,
  parameter int MUL_CYC = DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [AW-1:0] rd,
  output logic [AW-1:0] rf_rs,
  output logic [AW-1:0] rf_rt,
  input  logic [DW-1:0] rf_rdata_a,
  input  logic [DW-1:0] rf_rdata_b,
  output logic          rf_regWrite,
  output logic [AW-1:0] rf_rd,
  output logic [DW-1:0] rf_writeData,
  output logic          done,
  output logic          zero
);

  localparam int SHW = $clog2(DW);

  logic [1:0]    r_state;
  logic [2:0]    r_op;
  logic [AW-1:0] r_rs;
  logic [AW-1:0] r_rt;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wb_rd;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_wdata;
  logic          r_zero;

  logic [DW-1:0] w_alu;
  logic [DW-1:0] w_result;
  logic          w_exec_done;
  logic          w_mul_start;
  logic          w_mul_busy;
  logic          w_mul_done;
  logic [DW-1:0] w_mul_product;

  // The multiplier loads straight from the read ports at the end of READ,
  // so its first step lands in the first EXEC cycle.
  assign w_mul_start = (r_state == ST_READ) && is_mul(r_op);

  alu_writeback_stage_mul #(
    .DW    (DW),
    .STEPS (MUL_CYC)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_mul_start),
    .i_a       (rf_rdata_a),
    .i_b       (rf_rdata_b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  // Single-cycle ALU on the captured operands; shifts use only the low bits of B.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_SLL:  w_alu = r_a << r_b[SHW-1:0];
      OP_SRL:  w_alu = r_a >> r_b[SHW-1:0];
      default: w_alu = '0;
    endcase
  end

  assign w_result    = is_mul(r_op) ? w_mul_product : w_alu;
  assign w_exec_done = is_mul(r_op) ? w_mul_done : 1'b1;

  // Instruction FSM: IDLE -> READ -> EXEC (1 or MUL_CYC cycles) -> WB -> IDLE.
  always_ff @(posedge clk) begin
    // NOTE: every register is reset here, datapath included, because the
    // write-back outputs are defined to read zero straight out of reset.
    if (!reset) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_wb_rd <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_wdata <= '0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op    <= op;
            r_rs    <= rs;
            r_rt    <= rt;
            r_rd    <= rd;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          r_a     <= rf_rdata_a;
          r_b     <= rf_rdata_b;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (w_exec_done) begin
            r_wdata <= w_result;
            r_wb_rd <= r_rd;
            r_zero  <= (w_result == '0);
            r_state <= ST_WB;
          end
        end
        ST_WB:   r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = (r_state == ST_IDLE) && !w_mul_busy;
  assign rf_rs        = r_rs;
  assign rf_rt        = r_rt;
  assign rf_regWrite  = (r_state == ST_WB);
  assign done         = (r_state == ST_WB);
  assign rf_rd        = r_wb_rd;
  assign rf_writeData = r_wdata;
  assign zero         = r_zero;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: a behavioural register file drives the read
// ports and absorbs writes; directed cases plus random instructions are
// compared against an arithmetic reference model.
module tb_alu_writeback_stage;

  localparam int MUL_CYC = 16;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [3:0]  rs, rt, rd;
  logic [3:0]  rf_rs, rf_rt, rf_rd;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_writeData;
  logic        rf_regWrite, done, zero;

  // Bench-side register file plus a preload port used only while idle.
  logic [15:0] rf [16];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [15:0] pl_data;

  // Expected register contents, maintained by the reference model.
  logic [15:0] exp_rf [16];

  int n_checks = 0;
  int n_errors = 0;

  alu_writeback_stage #(.MUL_CYC(MUL_CYC)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .rf_rs        (rf_rs),
    .rf_rt        (rf_rt),
    .rf_rdata_a   (rf_rdata_a),
    .rf_rdata_b   (rf_rdata_b),
    .rf_regWrite  (rf_regWrite),
    .rf_rd        (rf_rd),
    .rf_writeData (rf_writeData),
    .done         (done),
    .zero         (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rdata_a = rf[rf_rs];
  assign rf_rdata_b = rf[rf_rt];

  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (rf_regWrite) rf[rf_rd] <= rf_writeData;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference ALU written as plain integer arithmetic.
  function automatic logic [15:0] ref_alu(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    longint ua, ub, r;
    ua = longint'(a);
    ub = longint'(b);
    case (o)
      3'd0:    r = ua + ub;
      3'd1:    r = ua - ub + 65536;
      3'd2:    r = longint'(a & b);
      3'd3:    r = longint'(a | b);
      3'd4:    r = longint'(a ^ b);
      3'd5:    r = ua * (longint'(1) << (ub % 16));
      3'd6:    r = ua / (longint'(1) << (ub % 16));
      default: r = ua * ub;
    endcase
    return r[15:0];
  endfunction

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    exp_rf[a] = d;
  endtask

  // Issue one instruction and check timing, write-back fields and the register file.
  task automatic run_op(input logic [2:0] t_op, input logic [3:0] t_rs,
                        input logic [3:0] t_rt, input logic [3:0] t_rd);
    logic [15:0] exp_val;
    int exp_lat, k, ready_hi;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("ready_before_issue", 32'(in_ready), 32'd1);
    exp_val = ref_alu(t_op, exp_rf[t_rs], exp_rf[t_rt]);
    exp_lat = (t_op == 3'b111) ? 2 + MUL_CYC : 3;
    op = t_op; rs = t_rs; rt = t_rt; rd = t_rd;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); rs = 4'($urandom); rt = 4'($urandom); rd = 4'($urandom);
    k = 1;
    ready_hi = 0;
    while (!rf_regWrite && k < 40) begin
      if (in_ready) ready_hi++;
      @(posedge clk); #1;
      k++;
    end
    if (in_ready) ready_hi++;
    check($sformatf("latency op%0d", t_op), 32'(k), 32'(exp_lat));
    check("in_ready_high_while_busy", 32'(ready_hi), 32'd0);
    check("wb_regWrite", 32'(rf_regWrite), 32'd1);
    check("wb_done", 32'(done), 32'd1);
    check("wb_rd", 32'(rf_rd), 32'(t_rd));
    check($sformatf("wb_data op%0d a=%0h b=%0h", t_op, exp_rf[t_rs], exp_rf[t_rt]),
          32'(rf_writeData), 32'(exp_val));
    check("wb_zero", 32'(zero), 32'(exp_val == 16'd0));
    @(posedge clk); #1;
    exp_rf[t_rd] = exp_val;
    check("post_wb_regWrite", 32'(rf_regWrite), 32'd0);
    check("post_wb_done", 32'(done), 32'd0);
    check("post_wb_zero_held", 32'(zero), 32'(exp_val == 16'd0));
    check("rf_dest_written", 32'(rf[t_rd]), 32'(exp_val));
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    op = '0; rs = '0; rt = '0; rd = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_regWrite", 32'(rf_regWrite), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_rf_rs", 32'(rf_rs), 32'd0);
    check("rst_rf_rd", 32'(rf_rd), 32'd0);
    check("rst_wdata", 32'(rf_writeData), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));

    // ADD
    preload(4'd1, 16'd1); preload(4'd3, 16'd3);
    run_op(3'b000, 4'd1, 4'd3, 4'd5);
    // SUB wrap, then zero result
    preload(4'd2, 16'd2); preload(4'd4, 16'd4);
    run_op(3'b001, 4'd2, 4'd4, 4'd12);
    run_op(3'b001, 4'd2, 4'd2, 4'd13);
    // MUL, then a product whose low half is zero
    preload(4'd7, 16'd7); preload(4'd9, 16'd9);
    run_op(3'b111, 4'd7, 4'd9, 4'd6);
    preload(4'd8, 16'h0100);
    run_op(3'b111, 4'd8, 4'd8, 4'd14);
    // Shift with upper B bits set, destination overlapping the source
    preload(4'd10, 16'h8001); preload(4'd11, 16'h0011);
    run_op(3'b101, 4'd10, 4'd11, 4'd10);
    run_op(3'b110, 4'd10, 4'd11, 4'd15);

    // Reset in the middle of a MUL: the write is aborted
    begin
      int wr_seen;
      logic [15:0] r6_before;
      r6_before = exp_rf[6];
      op = 3'b111; rs = 4'd7; rt = 4'd9; rd = 4'd6;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_regWrite", 32'(rf_regWrite), 32'd0);
      check("midrst_wdata", 32'(rf_writeData), 32'd0);
      check("midrst_rf_rd", 32'(rf_rd), 32'd0);
      check("midrst_zero", 32'(zero), 32'd0);
      wr_seen = 0;
      for (int c = 0; c < 25; c++) begin
        @(posedge clk); #1;
        if (rf_regWrite) wr_seen++;
      end
      check("midrst_no_write", 32'(wr_seen), 32'd0);
      check("midrst_r6_intact", 32'(rf[6]), 32'(r6_before));
      run_op(3'b000, 4'd1, 4'd3, 4'd5);
    end

    // Random instructions with occasional corner-value preloads
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0:       preload(4'($urandom), 16'h0000);
          1:       preload(4'($urandom), 16'hFFFF);
          2:       preload(4'($urandom), 16'h8000);
          default: preload(4'($urandom), 16'($urandom));
        endcase
      end
      run_op(3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
